watermark_monitor: RTL and testbench

Watches the occupancy level produced by an up/down occupancy counter and turns it into a debounced, hysteretic high-watermark alarm plus a single-entry interrupt event. Sits directly downstream of the counter: it consumes the counter value, the counter's sticky overflow and a sample strobe, and feeds the interrupt aggregator. It also reports the peak level of the most recent alarm episode.

---
 rtl/watermark_pkg.sv | 17 +
 rtl/irq_event_reg.sv | 50 +++++
 rtl/watermark_monitor.sv | 169 ++++++++++++++++
 tb/tb_watermark_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/watermark_pkg.sv
// Shared types for the watermark monitor: FSM states and interrupt cause bit layout.
package watermark_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_RISING  = 2'd1,
    ST_HIGH    = 2'd2,
    ST_FALLING = 2'd3
  } wm_state_e;

  localparam int CauseRise = 0;
  localparam int CauseFall = 1;
  localparam int CauseOvf  = 2;

  typedef logic [2:0] wm_cause_t;

endpackage

// File: rtl/irq_event_reg.sv
// Single-entry pending-event holder: events OR into the cause bits, a valid/ready handshake empties it.
// Registered outputs; an event arriving during a handshake becomes the new entry with only its own bits.
module irq_event_reg #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         set_i,
  input  logic [W-1:0] cause_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] cause_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] cause_q, cause_d;
  logic         hs;

  assign hs = valid_q & ready_i;

  always_comb begin
    valid_d = valid_q;
    cause_d = cause_q;
    if (clear_i) begin
      valid_d = 1'b0;
      cause_d = '0;
    end else if (set_i) begin
      valid_d = 1'b1;
      cause_d = hs ? cause_i : (cause_q | cause_i);
    end else if (hs) begin
      valid_d = 1'b0;
      cause_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      cause_q <= '0;
    end else begin
      valid_q <= valid_d;
      cause_q <= cause_d;
    end
  end

  assign valid_o = valid_q;
  assign cause_o = cause_q;

endmodule

// File: rtl/watermark_monitor.sv
// Debounced hysteretic high-watermark alarm with peak tracking and a single-entry interrupt.
// One cycle from qualifying sample (or overflow edge) to alarm_o/irq_valid_o; irq held until irq_ready_i.
module watermark_monitor
  import watermark_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PERSIST_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 level_valid_i,
  input  logic [WIDTH-1:0]     level_i,
  input  logic                 overflow_i,
  input  logic [WIDTH-1:0]     hi_thresh_i,
  input  logic [WIDTH-1:0]     lo_thresh_i,
  input  logic [PERSIST_W-1:0] persist_i,
  output logic                 alarm_o,
  output logic [WIDTH-1:0]     peak_o,
  output logic                 irq_valid_o,
  input  logic                 irq_ready_i,
  output logic [2:0]           irq_cause_o
);

  localparam logic [PERSIST_W-1:0] CntOne = PERSIST_W'(1);

  wm_state_e            state_q, state_d;
  logic [PERSIST_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0]     peak_q, peak_d;
  logic                 alarm_q, alarm_d;
  logic                 ovf_q, ovf_d;

  logic      rise, fall, ovf_edge, fast, cnt_done;
  logic      ev_rise, ev_fall, ev_ovf;
  wm_cause_t cause;

  // Fall also requires being below hi so a misconfigured lo >= hi cannot make the alarm chatter.
  assign rise     = (level_i >= hi_thresh_i);
  assign fall     = (level_i <= lo_thresh_i) && (level_i < hi_thresh_i);
  assign ovf_edge = overflow_i & ~ovf_q;
  assign fast     = (persist_i <= CntOne);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;
  assign cnt_done = (cnt_inc >= persist_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      peak_q  <= '0;
      alarm_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      alarm_q <= alarm_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_rise = 1'b0;
    ev_fall = 1'b0;
    ev_ovf  = 1'b0;
    if (clear_i) begin
      state_d = ST_LOW;
      cnt_d   = '0;
    end else if (ovf_edge) begin
      state_d = ST_HIGH;
      cnt_d   = '0;
      ev_ovf  = 1'b1;
      ev_rise = (state_q == ST_LOW) || (state_q == ST_RISING);
    end else if (level_valid_i) begin
      unique case (state_q)
        ST_LOW: begin
          if (rise) begin
            if (fast) begin
              state_d = ST_HIGH;
              cnt_d   = '0;
              ev_rise = 1'b1;
            end else begin
              state_d = ST_RISING;
              cnt_d   = CntOne;
            end
          end
        end
        ST_RISING: begin
          if (!rise) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt_done) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
            ev_rise = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_HIGH: begin
          // A sustained overflow pins the alarm: no fall path while overflow_i is high.
          if (fall && !overflow_i) begin
            if (fast) begin
              state_d = ST_LOW;
              cnt_d   = '0;
              ev_fall = 1'b1;
            end else begin
              state_d = ST_FALLING;
              cnt_d   = CntOne;
            end
          end
        end
        ST_FALLING: begin
          if (!fall || overflow_i) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt_done) begin
            state_d = ST_LOW;
            cnt_d   = '0;
            ev_fall = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    cause            = '0;
    cause[CauseRise] = ev_rise;
    cause[CauseFall] = ev_fall;
    cause[CauseOvf]  = ev_ovf;
    alarm_d          = (state_d == ST_HIGH) || (state_d == ST_FALLING);
    ovf_d            = clear_i ? 1'b0 : overflow_i;
    peak_d           = peak_q;
    if (clear_i) begin
      peak_d = '0;
    end else if (level_valid_i) begin
      if (state_q != ST_LOW) begin
        peak_d = (level_i > peak_q) ? level_i : peak_q;
      end else if (rise && !ovf_edge) begin
        peak_d = level_i;
      end
    end
  end

  irq_event_reg #(
    .W($bits(wm_cause_t))
  ) u_irq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .set_i   (|cause),
    .cause_i (cause),
    .ready_i (irq_ready_i),
    .valid_o (irq_valid_o),
    .cause_o (irq_cause_o)
  );

  assign alarm_o = alarm_q;
  assign peak_o  = peak_q;

endmodule

// File: tb/tb_watermark_monitor.sv
// Directed scenarios followed by randomized traffic, all checked every cycle against a streak-count model.
module tb_watermark_monitor;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       clear_i = 1'b0;
  logic       level_valid_i = 1'b0;
  logic [3:0] level_i = '0;
  logic       overflow_i = 1'b0;
  logic [3:0] hi_thresh_i = 4'd8;
  logic [3:0] lo_thresh_i = 4'd4;
  logic [3:0] persist_i = 4'd3;
  logic       alarm_o;
  logic [3:0] peak_o;
  logic       irq_valid_o;
  logic       irq_ready_i = 1'b0;
  logic [2:0] irq_cause_o;

  int passed = 0;
  int total  = 0;

  // Model: alarm flag plus length of the current run of qualifying samples.
  bit       m_alarm;
  int       m_streak;
  int       m_peak;
  bit       m_pv;
  bit [2:0] m_pc;
  bit       m_prev_ovf;

  watermark_monitor dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .level_valid_i (level_valid_i),
    .level_i       (level_i),
    .overflow_i    (overflow_i),
    .hi_thresh_i   (hi_thresh_i),
    .lo_thresh_i   (lo_thresh_i),
    .persist_i     (persist_i),
    .alarm_o       (alarm_o),
    .peak_o        (peak_o),
    .irq_valid_o   (irq_valid_o),
    .irq_ready_i   (irq_ready_i),
    .irq_cause_o   (irq_cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_alarm = 0; m_streak = 0; m_peak = 0; m_pv = 0; m_pc = '0; m_prev_ovf = 0;
  endtask

  task automatic model_step();
    int  lvl, hi, lo, p;
    bit  is_rise, is_fall, edge_ovf, in_low, hs;
    bit [2:0] ev;
    if (clear_i) begin
      model_reset();
    end else begin
      lvl = int'(level_i); hi = int'(hi_thresh_i); lo = int'(lo_thresh_i); p = int'(persist_i);
      is_rise  = (lvl >= hi);
      is_fall  = (lvl <= lo) && (lvl < hi);
      edge_ovf = overflow_i && !m_prev_ovf;
      in_low   = !m_alarm && (m_streak == 0);
      if (level_valid_i) begin
        if (!in_low) m_peak = (lvl > m_peak) ? lvl : m_peak;
        else if (is_rise && !edge_ovf) m_peak = lvl;
      end
      ev = '0;
      if (edge_ovf) begin
        ev = m_alarm ? 3'b100 : 3'b101;
        m_alarm = 1; m_streak = 0;
      end else if (level_valid_i) begin
        if (!m_alarm) begin
          if (is_rise) begin
            m_streak++;
            if (m_streak >= p) begin m_alarm = 1; m_streak = 0; ev = 3'b001; end
          end else m_streak = 0;
        end else begin
          if (is_fall && !overflow_i) begin
            m_streak++;
            if (m_streak >= p) begin m_alarm = 0; m_streak = 0; ev = 3'b010; end
          end else m_streak = 0;
        end
      end
      hs = m_pv && irq_ready_i;
      if (ev != 0) begin
        m_pc = hs ? ev : (m_pc | ev);
        m_pv = 1;
      end else if (hs) begin
        m_pv = 0; m_pc = '0;
      end
      m_prev_ovf = overflow_i;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("alarm", 32'(alarm_o), 32'(m_alarm));
    chk("peak", 32'(peak_o), 32'(m_peak));
    chk("irq_valid", 32'(irq_valid_o), 32'(m_pv));
    chk("irq_cause", 32'(irq_cause_o), 32'(m_pc));
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    #1;
    check_all();
  endtask

  task automatic samp(input logic [3:0] lvl);
    level_valid_i = 1'b1; level_i = lvl;
    cycle();
    level_valid_i = 1'b0;
  endtask

  task automatic ack();
    irq_ready_i = 1'b1;
    cycle();
    irq_ready_i = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    chk("reset_alarm", 32'(alarm_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Rise with persistence 3
    hi_thresh_i = 4'd8; lo_thresh_i = 4'd4; persist_i = 4'd3;
    samp(4'd8); samp(4'd9);
    chk("rise_early", 32'(alarm_o), 32'd0);
    samp(4'd8);
    chk("rise_alarm", 32'(alarm_o), 32'd1);
    chk("rise_cause", 32'(irq_cause_o), 32'b001);
    chk("rise_peak", 32'(peak_o), 32'd9);
    ack();
    samp(4'd2); samp(4'd2); samp(4'd2);
    chk("fall3_alarm", 32'(alarm_o), 32'd0);
    ack();

    // Interrupted rise
    samp(4'd9); samp(4'd9); samp(4'd7);
    chk("interrupt_alarm", 32'(alarm_o), 32'd0);
    samp(4'd9);
    chk("interrupt_irq", 32'(irq_valid_o), 32'd0);
    samp(4'd0);

    // Fall path with a non-fall sample in the middle
    persist_i = 4'd2;
    samp(4'd9); samp(4'd9);
    ack();
    samp(4'd3); samp(4'd5); samp(4'd4);
    chk("falling_alarm", 32'(alarm_o), 32'd1);
    samp(4'd4);
    chk("fall_alarm", 32'(alarm_o), 32'd0);
    chk("fall_cause", 32'(irq_cause_o), 32'b010);
    ack();

    // Overflow edge in LOW, then an unacknowledged fall merges
    overflow_i = 1'b1; cycle(); overflow_i = 1'b0;
    chk("ovf_alarm", 32'(alarm_o), 32'd1);
    chk("ovf_cause", 32'(irq_cause_o), 32'b101);
    samp(4'd2); samp(4'd2);
    chk("merge_cause", 32'(irq_cause_o), 32'b111);

    // New rise event coinciding with a handshake
    persist_i = 4'd1; irq_ready_i = 1'b1;
    samp(4'd9);
    irq_ready_i = 1'b0;
    chk("hs_valid", 32'(irq_valid_o), 32'd1);
    chk("hs_cause", 32'(irq_cause_o), 32'b001);

    // Async reset while FALLING with irq pending
    persist_i = 4'd3;
    samp(4'd2);
    #3 rst_i = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst_valid", 32'(irq_valid_o), 32'd0);
    #2 rst_i = 1'b0;
    samp(4'd5); samp(4'd7);
    chk("post_rst_alarm", 32'(alarm_o), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      level_valid_i = ($urandom_range(0, 9) < 7);
      level_i       = 4'($urandom_range(0, 15));
      irq_ready_i   = ($urandom_range(0, 2) == 0);
      clear_i       = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) overflow_i = ~overflow_i;
      if ($urandom_range(0, 19) == 0) begin
        hi_thresh_i = 4'($urandom_range(6, 12));
        lo_thresh_i = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(1, 6));
        persist_i   = 4'($urandom_range(0, 4));
      end
      cycle();
    end
    clear_i = 1'b0; level_valid_i = 1'b0; overflow_i = 1'b0; irq_ready_i = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
